// File: rtl/psp_rvfi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psp_rvfi_pkg
//  Description : RVFI retirement packet type and canonicalisation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package psp_rvfi_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_pkt_t;

    localparam int RVFI_PKT_W = $bits(rvfi_pkt_t);

    // Zero the fields RVFI treats as don't-care so traces compare bit-exact.
    function automatic rvfi_pkt_t rvfi_canon(input rvfi_pkt_t pkt);
        rvfi_pkt_t res;
        res = pkt;
        if (pkt.rd_addr == 5'd0)
            res.rd_wdata = '0;
        if (pkt.mem_rmask == 4'd0)
            res.mem_rdata = '0;
        if (pkt.mem_wmask == 4'd0)
            res.mem_wdata = '0;
        if ((pkt.mem_rmask == 4'd0) && (pkt.mem_wmask == 4'd0))
            res.mem_addr = '0;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psp_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : psp_sync_fifo
//  Description : Generic synchronous FIFO with circular pointers, count and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module psp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_ptr_w-1:0] w_wr_nxt;
    logic [c_ptr_w-1:0] w_rd_nxt;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    // A flush discards the head, so a concurrent pop has nothing to remove.
    assign w_do_pop  = pop && !empty && !flush;
    assign w_wr_nxt  = (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
    assign w_rd_nxt  = (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= w_wr_nxt;
            if (flush) begin
                // Head jumps to the write slot; a same-cycle push survives as sole entry.
                r_rd_ptr <= r_wr_ptr;
                r_count  <= w_do_push ? c_cnt_w'(1) : '0;
            end else begin
                if (w_do_pop)
                    r_rd_ptr <= w_rd_nxt;
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psp_rvfi_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : psp_rvfi_emitter
//  Description : Stamps retiring instructions with a monotonic order, canonicalises
//                them and queues them for a valid/ready RVFI trace consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module psp_rvfi_emitter
    import psp_rvfi_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ret_valid,
    output logic               ret_ready,
    input  rvfi_pkt_t          ret_pkt,
    input  logic               flush,
    output logic               trace_valid,
    input  logic               trace_ready,
    output rvfi_pkt_t          trace_pkt,
    output logic [ORDER_W-1:0] trace_order,
    output logic               overflow_err
);

    localparam int c_entry_w = ORDER_W + RVFI_PKT_W;

    logic [ORDER_W-1:0]   r_order;
    logic                 r_overflow;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_head;

    assign ret_ready    = !w_full;
    assign trace_valid  = !w_empty;
    assign w_push       = ret_valid && ret_ready;
    assign w_pop        = trace_valid && trace_ready;
    assign w_push_data  = {r_order, rvfi_canon(ret_pkt)};
    assign trace_order  = w_head[c_entry_w-1:RVFI_PKT_W];
    assign trace_pkt    = rvfi_pkt_t'(w_head[RVFI_PKT_W-1:0]);
    assign overflow_err = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_order <= '0;
        else if (w_push)
            r_order <= r_order + ORDER_W'(1);
    end

    // Sticky until reset: a dropped retirement makes the whole trace untrustworthy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_overflow <= 1'b0;
        else if (ret_valid && !ret_ready)
            r_overflow <= 1'b1;
    end

    psp_sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_psp_rvfi_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psp_rvfi_emitter
//  Description : Self-checking bench for psp_rvfi_emitter against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psp_rvfi_emitter;
    import psp_rvfi_pkg::*;

    localparam int c_depth = 4;

    typedef struct packed {
        logic [63:0] ord;
        rvfi_pkt_t   pkt;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        ret_valid;
    logic        ret_ready;
    rvfi_pkt_t   ret_pkt;
    logic        flush;
    logic        trace_valid;
    logic        trace_ready;
    rvfi_pkt_t   trace_pkt;
    logic [63:0] trace_order;
    logic        overflow_err;

    int          n_tests;
    int          n_fail;
    ent_t        mq[$];
    logic [63:0] m_ord;
    logic        m_ovf;

    psp_rvfi_emitter #(
        .DEPTH   (c_depth),
        .ORDER_W (64)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ret_valid    (ret_valid),
        .ret_ready    (ret_ready),
        .ret_pkt      (ret_pkt),
        .flush        (flush),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pkt    (trace_pkt),
        .trace_order  (trace_order),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic rvfi_pkt_t model_canon(input rvfi_pkt_t p);
        rvfi_pkt_t r;
        r = p;
        if (p.rd_addr == 0)   r.rd_wdata  = 0;
        if (p.mem_rmask == 0) r.mem_rdata = 0;
        if (p.mem_wmask == 0) r.mem_wdata = 0;
        if (p.mem_rmask == 0 && p.mem_wmask == 0) r.mem_addr = 0;
        return r;
    endfunction

    function automatic rvfi_pkt_t rand_pkt();
        rvfi_pkt_t p;
        p.insn      = $urandom;
        p.rs1_addr  = 5'($urandom);
        p.rs1_rdata = $urandom;
        p.rs2_addr  = 5'($urandom);
        p.rs2_rdata = $urandom;
        p.rd_addr   = 5'($urandom_range(0, 3));
        p.rd_wdata  = $urandom;
        p.pc_rdata  = $urandom;
        p.pc_wdata  = $urandom;
        p.mem_addr  = $urandom;
        p.mem_rmask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
        p.mem_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
        p.mem_rdata = $urandom;
        p.mem_wdata = $urandom;
        return p;
    endfunction

    function automatic rvfi_pkt_t pc_pkt(input logic [31:0] pc);
        rvfi_pkt_t p;
        p = rand_pkt();
        p.pc_rdata = pc;
        return p;
    endfunction

    task automatic check_outputs();
        check_eq("ret_ready", ret_ready, mq.size() != c_depth);
        check_eq("trace_valid", trace_valid, mq.size() != 0);
        check_eq("overflow_err", overflow_err, m_ovf);
        if (mq.size() != 0) begin
            check_eq("trace_order", trace_order, mq[0].ord);
            check_eq("trace_pkt", trace_pkt, mq[0].pkt);
        end
    endtask

    // Called at a negedge: check, drive, advance one cycle, update model.
    task automatic step(input logic v, input rvfi_pkt_t p, input logic tr, input logic fl);
        int   n;
        ent_t e;
        check_outputs();
        ret_valid   = v;
        ret_pkt     = p;
        trace_ready = tr;
        flush       = fl;
        @(posedge clk);
        n = mq.size();
        if (v && n == c_depth) m_ovf = 1'b1;
        if (fl) mq.delete();
        else if (tr && n > 0) void'(mq.pop_front());
        if (v && n < c_depth) begin
            e.ord = m_ord;
            e.pkt = model_canon(p);
            mq.push_back(e);
            m_ord = m_ord + 64'd1;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ord = '0;
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        ret_valid   = 1'b0;
        ret_pkt     = '0;
        trace_ready = 1'b0;
        flush       = 1'b0;
        reset_n     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_trace_valid", trace_valid, 1'b0);
        check_eq("rst_ret_ready", ret_ready, 1'b1);
        check_eq("rst_overflow", overflow_err, 1'b0);
        check_eq("rst_trace_order", trace_order, 64'd0);
        check_eq("rst_trace_pkt", trace_pkt, '0);
        reset_n = 1'b1;
    endtask

    initial begin
        rvfi_pkt_t p;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        ret_valid = 1'b0;
        ret_pkt = '0;
        trace_ready = 1'b0;
        flush = 1'b0;
        model_reset();

        // Reset state
        do_reset();

        // Three pushes streamed straight through
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pc_pkt(32'h6000_0000 + 32'(4 * i)), 1'b1, 1'b0);
            check_eq("t2_order", trace_order, 64'(i));
            check_eq("t2_pc", trace_pkt.pc_rdata, 32'h6000_0000 + 32'(4 * i));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t2_drained", trace_valid, 1'b0);

        // Overfill with consumer stalled
        do_reset();
        for (int i = 0; i < c_depth + 1; i++)
            step(1'b1, rand_pkt(), 1'b0, 1'b0);
        check_eq("t3_ret_ready", ret_ready, 1'b0);
        check_eq("t3_overflow", overflow_err, 1'b1);
        for (int i = 0; i < c_depth; i++) begin
            check_eq("t3_order", trace_order, 64'(i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("t3_no_fifth", trace_valid, 1'b0);

        // Canonicalisation
        do_reset();
        p = rand_pkt();
        p.rd_addr = 5'd0;
        p.rd_wdata = 32'hDEAD_BEEF;
        p.mem_rmask = 4'd0;
        p.mem_wmask = 4'd0;
        p.mem_addr = 32'h1234;
        step(1'b1, p, 1'b0, 1'b0);
        check_eq("t4_rd_wdata", trace_pkt.rd_wdata, 32'd0);
        check_eq("t4_mem_addr", trace_pkt.mem_addr, 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush with same-cycle push and pop
        do_reset();
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        step(1'b1, pc_pkt(32'h100), 1'b1, 1'b1);
        check_eq("t5_valid", trace_valid, 1'b1);
        check_eq("t5_pc", trace_pkt.pc_rdata, 32'h100);
        check_eq("t5_order", trace_order, 64'd2);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t5_single", trace_valid, 1'b0);

        // Order counter wrap and asynchronous reset
        do_reset();
        @(negedge clk);
        dut.r_order = {64{1'b1}};
        m_ord = {64{1'b1}};
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        check_eq("t6_order_max", trace_order, {64{1'b1}});
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t6_order_wrap", trace_order, 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        ret_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_async_valid", trace_valid, 1'b0);
        check_eq("t6_async_order", trace_order, 64'd0);
        model_reset();
        @(negedge clk);

        // Randomised traffic including flushes and occasional illegal pushes
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic v;
            v = ($urandom_range(0, 9) < 7) &&
                ((mq.size() < c_depth) || ($urandom_range(0, 19) == 0));
            step(v, rand_pkt(), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
